// File: rtl/pmp_96_if.sv
// Bus between the core's address path and the PMP checker: PMP CSR state,
// the access being checked, and the registered grant.
interface pmp_96_if #(
  parameter int unsigned pmp_msb = 55
);
  logic [0:15][pmp_msb-2:0] pmpaddr;
  logic [63:0]              pmpcfg0;
  logic [63:0]              pmpcfg2;
  logic [pmp_msb:0]         address;
  logic [1:0]               acc;
  logic [1:0]               prv;
  logic                     mprv;
  logic [1:0]               mpp;
  logic                     valid;
  logic                     ok;

  modport master (
    output pmpaddr, pmpcfg0, pmpcfg2, address, acc, prv, mprv, mpp, valid,
    input  ok
  );

  modport slave (
    input  pmpaddr, pmpcfg0, pmpcfg2, address, acc, prv, mprv, mpp, valid,
    output ok
  );
endinterface

// File: rtl/pmp_96.sv
// RV64 PMP checker: matches a physical address against 16 PMP entries and
// returns a registered grant one cycle after the inputs are presented.
module pmp_96 #(
  parameter int unsigned pmp_check   = 1,
  parameter int unsigned pmp_no_tor  = 1,
  parameter int unsigned pmp_entries = 16,
  parameter int unsigned pmp_g       = 10,
  parameter int unsigned pmp_msb     = 55
) (
  input logic       clk300p,
  input logic       rstn,
  pmp_96_if.slave   bus
);

  localparam int unsigned aw = pmp_msb - 1;
  typedef logic [aw-1:0] word_t;

  // TOR compares ignore address bits below the grain.
  localparam word_t tor_mask    = ~word_t'((64'(1) << pmp_g) - 64'(1));
  // NAPOT regions are at least one grain, so the low G-1 bits read as ones.
  localparam word_t napot_force = (pmp_g >= 2) ?
                                  word_t'((64'(1) << (pmp_g - 1)) - 64'(1)) : '0;

  // Config field decode
  logic [15:0]      cfg_r, cfg_w, cfg_x, cfg_l;
  logic [15:0][1:0] cfg_a;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cfg_r[i]     = bus.pmpcfg0[8*i];
      cfg_w[i]     = bus.pmpcfg0[8*i+1];
      cfg_x[i]     = bus.pmpcfg0[8*i+2];
      cfg_a[i]     = bus.pmpcfg0[8*i+3 +: 2];
      cfg_l[i]     = bus.pmpcfg0[8*i+7];
      cfg_r[i+8]   = bus.pmpcfg2[8*i];
      cfg_w[i+8]   = bus.pmpcfg2[8*i+1];
      cfg_x[i+8]   = bus.pmpcfg2[8*i+2];
      cfg_a[i+8]   = bus.pmpcfg2[8*i+3 +: 2];
      cfg_l[i+8]   = bus.pmpcfg2[8*i+7];
    end
  end

  word_t wa;
  word_t wa_tor;
  assign wa     = bus.address[pmp_msb:2];
  assign wa_tor = wa & tor_mask;

  logic [15:0] match;

  for (genvar i = 0; i < 16; i++) begin : g_entry
    logic [1:0] mode;
    word_t      p;
    word_t      lo;
    word_t      p_tor;
    word_t      lo_tor;
    word_t      p_nap;
    logic [aw:0] p_inc;
    logic [aw:0] p_flip;
    word_t      nap_mask;
    logic       tor_hit;
    logic       na4_hit;
    logic       napot_hit;
    logic       hit;

    assign mode = (i < pmp_entries) ? cfg_a[i] : 2'b00;
    assign p    = bus.pmpaddr[i];

    if (i == 0) begin : g_lo_zero
      assign lo = '0;
    end else begin : g_lo_prev
      assign lo = bus.pmpaddr[i-1];
    end

    assign p_tor   = p & tor_mask;
    assign lo_tor  = lo & tor_mask;
    assign tor_hit = (pmp_no_tor == 0) && (lo_tor < p_tor) &&
                     (lo_tor <= wa_tor) && (wa_tor < p_tor);

    assign na4_hit = (pmp_g == 0) && (wa == p);

    // Extra carry bit keeps an all-ones pmpaddr from wrapping; its mask is then
    // all zeros and the entry covers the whole address space.
    assign p_nap     = p | napot_force;
    assign p_inc     = {1'b0, p_nap} + {{aw{1'b0}}, 1'b1};
    assign p_flip    = {1'b0, p_nap} ^ p_inc;
    assign nap_mask  = ~p_flip[aw-1:0];
    assign napot_hit = ((wa ^ p_nap) & nap_mask) == '0;

    always_comb begin
      hit = 1'b0;
      unique case (mode)
        2'b01:   hit = tor_hit;
        2'b10:   hit = na4_hit;
        2'b11:   hit = napot_hit;
        default: hit = 1'b0;
      endcase
    end

    assign match[i] = hit;
  end

  // Effective privilege: M with MPRV set takes MPP for loads/stores only.
  logic [1:0] eff_prv;
  logic       eff_m;

  always_comb begin
    eff_prv = bus.prv;
    if (bus.prv == 2'b11 && bus.mprv && bus.acc != 2'b00) begin
      eff_prv = bus.mpp;
    end
    eff_m = (eff_prv == 2'b11);
  end

  // Lowest-numbered matching entry wins.
  logic found;
  logic win_r, win_w, win_x, win_l;

  always_comb begin
    found = 1'b0;
    win_r = 1'b0;
    win_w = 1'b0;
    win_x = 1'b0;
    win_l = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (match[i]) begin
        found = 1'b1;
        win_r = cfg_r[i];
        win_w = cfg_w[i];
        win_x = cfg_x[i];
        win_l = cfg_l[i];
      end
    end
  end

  logic perm;
  logic ok_d;
  logic ok_q;

  always_comb begin
    perm = win_r;
    unique case (bus.acc)
      2'b00:   perm = win_x;
      2'b11:   perm = win_w;
      default: perm = win_r;
    endcase

    ok_d = eff_m;
    if (pmp_check == 0) begin
      ok_d = 1'b1;
    end else if (found) begin
      ok_d = (!win_l && eff_m) ? 1'b1 : perm;
    end
  end

  always_ff @(posedge clk300p or negedge rstn) begin
    if (!rstn) begin
      ok_q <= 1'b0;
    end else begin
      ok_q <= ok_d;
    end
  end

  assign bus.ok = ok_q;

  // Access size is implied by the grain, and valid does not gate the grant.
  logic unused_in;
  assign unused_in = ^{bus.valid, bus.address[1:0], bus.pmpcfg0, bus.pmpcfg2};

endmodule

// File: tb/tb_pmp_96.sv
// Directed bench for pmp_96: default build plus TOR/NA4 (G=0), no-TOR and
// PMP-disabled variants sharing one set of stimulus.
module tb_pmp_96;

  logic clk300p = 1'b0;
  logic rstn    = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk300p = ~clk300p;

  pmp_96_if #(.pmp_msb(55)) bus ();
  pmp_96_if #(.pmp_msb(55)) bus_tor ();
  pmp_96_if #(.pmp_msb(55)) bus_notor ();
  pmp_96_if #(.pmp_msb(55)) bus_off ();

  assign bus_tor.pmpaddr   = bus.pmpaddr;
  assign bus_tor.pmpcfg0   = bus.pmpcfg0;
  assign bus_tor.pmpcfg2   = bus.pmpcfg2;
  assign bus_tor.address   = bus.address;
  assign bus_tor.acc       = bus.acc;
  assign bus_tor.prv       = bus.prv;
  assign bus_tor.mprv      = bus.mprv;
  assign bus_tor.mpp       = bus.mpp;
  assign bus_tor.valid     = bus.valid;
  assign bus_notor.pmpaddr = bus.pmpaddr;
  assign bus_notor.pmpcfg0 = bus.pmpcfg0;
  assign bus_notor.pmpcfg2 = bus.pmpcfg2;
  assign bus_notor.address = bus.address;
  assign bus_notor.acc     = bus.acc;
  assign bus_notor.prv     = bus.prv;
  assign bus_notor.mprv    = bus.mprv;
  assign bus_notor.mpp     = bus.mpp;
  assign bus_notor.valid   = bus.valid;
  assign bus_off.pmpaddr   = bus.pmpaddr;
  assign bus_off.pmpcfg0   = bus.pmpcfg0;
  assign bus_off.pmpcfg2   = bus.pmpcfg2;
  assign bus_off.address   = bus.address;
  assign bus_off.acc       = bus.acc;
  assign bus_off.prv       = bus.prv;
  assign bus_off.mprv      = bus.mprv;
  assign bus_off.mpp       = bus.mpp;
  assign bus_off.valid     = bus.valid;

  pmp_96 u_dut (
    .clk300p (clk300p),
    .rstn    (rstn),
    .bus     (bus)
  );

  pmp_96 #(.pmp_no_tor(0), .pmp_g(0)) u_dut_tor (
    .clk300p (clk300p),
    .rstn    (rstn),
    .bus     (bus_tor)
  );

  pmp_96 #(.pmp_no_tor(1), .pmp_g(0)) u_dut_notor (
    .clk300p (clk300p),
    .rstn    (rstn),
    .bus     (bus_notor)
  );

  pmp_96 #(.pmp_check(0)) u_dut_off (
    .clk300p (clk300p),
    .rstn    (rstn),
    .bus     (bus_off)
  );

  localparam logic [1:0] AccX = 2'b00, AccR = 2'b01, AccW = 2'b11;
  localparam logic [1:0] PrvU = 2'b00, PrvS = 2'b01, PrvM = 2'b11;

  task automatic clear_cfg();
    bus.pmpaddr = '0;
    bus.pmpcfg0 = '0;
    bus.pmpcfg2 = '0;
  endtask

  // Present one access at the falling edge and sample 1 ns after the next rising edge.
  task automatic access(input logic [55:0] addr, input logic [1:0] acc,
                        input logic [1:0] prv, input logic mprv, input logic [1:0] mpp);
    @(negedge clk300p);
    bus.address = addr;
    bus.acc     = acc;
    bus.prv     = prv;
    bus.mprv    = mprv;
    bus.mpp     = mpp;
    bus.valid   = 1'b1;
    @(posedge clk300p);
    #1;
  endtask

  task automatic test_reset();
    clear_cfg();
    bus.address = '0;
    bus.acc     = AccR;
    bus.prv     = PrvU;
    bus.mprv    = 1'b0;
    bus.mpp     = PrvU;
    bus.valid   = 1'b0;
    rstn        = 1'b0;
    repeat (2) @(posedge clk300p);
    #1;
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL reset_main ok=%b exp=0", bus.ok);
    end
    checks++;
    if (bus_tor.ok !== 1'b0) begin
      failures++; $display("FAIL reset_tor ok=%b exp=0", bus_tor.ok);
    end
    checks++;
    if (bus_off.ok !== 1'b0) begin
      failures++; $display("FAIL reset_off ok=%b exp=0", bus_off.ok);
    end
    @(negedge clk300p);
    rstn = 1'b1;
    @(posedge clk300p);
    #1;
    checks++;
    if (bus_off.ok !== 1'b1) begin
      failures++; $display("FAIL reset_release_off ok=%b exp=1", bus_off.ok);
    end
  endtask

  task automatic test_napot();
    clear_cfg();
    bus.pmpaddr[0] = 54'h1FFFF;
    bus.pmpcfg0    = 64'h1B;
    access(56'h1000, AccR, PrvU, 1'b0, PrvU);
    checks++;
    if (bus.ok !== 1'b1) begin
      failures++; $display("FAIL napot_read ok=%b exp=1", bus.ok);
    end
    access(56'h1000, AccX, PrvU, 1'b0, PrvU);
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL napot_exec ok=%b exp=0", bus.ok);
    end
    checks++;
    if (bus_off.ok !== 1'b1) begin
      failures++; $display("FAIL disabled_exec ok=%b exp=1", bus_off.ok);
    end
  endtask

  task automatic test_lock_priority();
    clear_cfg();
    bus.pmpaddr[0] = 54'hFFFF;
    bus.pmpaddr[1] = '1;
    bus.pmpcfg0    = 64'h1F98;
    access(56'h100, AccW, PrvM, 1'b0, PrvU);
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL lock_m_write ok=%b exp=0", bus.ok);
    end
    access(56'h100000, AccW, PrvM, 1'b0, PrvU);
    checks++;
    if (bus.ok !== 1'b1) begin
      failures++; $display("FAIL priority_entry1 ok=%b exp=1", bus.ok);
    end
  endtask

  task automatic test_no_match();
    clear_cfg();
    access(56'h2000, AccR, PrvS, 1'b0, PrvU);
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL nomatch_s ok=%b exp=0", bus.ok);
    end
    access(56'h2000, AccR, PrvM, 1'b0, PrvU);
    checks++;
    if (bus.ok !== 1'b1) begin
      failures++; $display("FAIL nomatch_m ok=%b exp=1", bus.ok);
    end
    access(56'h2000, AccR, PrvM, 1'b1, PrvU);
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL nomatch_mprv_r ok=%b exp=0", bus.ok);
    end
    access(56'h2000, AccX, PrvM, 1'b1, PrvU);
    checks++;
    if (bus.ok !== 1'b1) begin
      failures++; $display("FAIL nomatch_mprv_x ok=%b exp=1", bus.ok);
    end
  endtask

  task automatic test_mprv();
    clear_cfg();
    bus.pmpaddr[0] = 54'h1FFFF;
    bus.pmpcfg0    = 64'h19;
    access(56'h1000, AccR, PrvM, 1'b1, PrvS);
    checks++;
    if (bus.ok !== 1'b1) begin
      failures++; $display("FAIL mprv_read ok=%b exp=1", bus.ok);
    end
    access(56'h1000, AccW, PrvM, 1'b1, PrvS);
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL mprv_write ok=%b exp=0", bus.ok);
    end
  endtask

  task automatic test_tor();
    clear_cfg();
    bus.pmpaddr[0] = 54'h400;
    bus.pmpaddr[1] = 54'h800;
    bus.pmpcfg0    = 64'h0B00;
    access(56'h1000, AccR, PrvU, 1'b0, PrvU);
    checks++;
    if (bus_tor.ok !== 1'b1) begin
      failures++; $display("FAIL tor_inside ok=%b exp=1", bus_tor.ok);
    end
    checks++;
    if (bus_notor.ok !== 1'b0) begin
      failures++; $display("FAIL tor_unsupported ok=%b exp=0", bus_notor.ok);
    end
    access(56'h2000, AccR, PrvU, 1'b0, PrvU);
    checks++;
    if (bus_tor.ok !== 1'b0) begin
      failures++; $display("FAIL tor_upper_bound ok=%b exp=0", bus_tor.ok);
    end
  endtask

  task automatic test_na4();
    clear_cfg();
    bus.pmpaddr[0] = 54'h400;
    bus.pmpcfg0    = 64'h13;
    access(56'h1000, AccR, PrvU, 1'b0, PrvU);
    checks++;
    if (bus_tor.ok !== 1'b1) begin
      failures++; $display("FAIL na4_g0 ok=%b exp=1", bus_tor.ok);
    end
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL na4_coarse_grain ok=%b exp=0", bus.ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] addrs [3];
    logic        exp   [3];
    addrs = '{56'h1000, 56'h200000, 56'h1000};
    exp   = '{1'b1, 1'b0, 1'b1};
    clear_cfg();
    bus.pmpaddr[0] = 54'h1FFFF;
    bus.pmpcfg0    = 64'h1B;
    for (int i = 0; i < 3; i++) begin
      access(addrs[i], AccR, PrvU, 1'b0, PrvU);
      checks++;
      if (bus.ok !== exp[i]) begin
        failures++; $display("FAIL b2b_%0d ok=%b exp=%b", i, bus.ok, exp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_cfg();
    bus.pmpaddr[0] = 54'h1FFFF;
    bus.pmpcfg0    = 64'h1B;
    access(56'h1000, AccR, PrvU, 1'b0, PrvU);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL async_assert ok=%b exp=0", bus.ok);
    end
    @(negedge clk300p);
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.ok !== 1'b0) begin
      failures++; $display("FAIL async_release_hold ok=%b exp=0", bus.ok);
    end
    @(posedge clk300p);
    #1;
    checks++;
    if (bus.ok !== 1'b1) begin
      failures++; $display("FAIL async_first_edge ok=%b exp=1", bus.ok);
    end
  endtask

  initial begin
    test_reset();
    test_napot();
    test_lock_priority();
    test_no_match();
    test_mprv();
    test_tor();
    test_na4();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
